// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg
//   Shared definitions for the multi-cycle MIPS main control:
//   state encodings, opcode constants, ALUop codes, datapath
//   select codes and the packed control word that the decoder
//   produces.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    st_fetch  = 4'd0,
    st_decode = 4'd1,
    st_memadr = 4'd2,
    st_memrd  = 4'd3,
    st_memwb  = 4'd4,
    st_memwr  = 4'd5,
    st_rtex   = 4'd6,
    st_rtwb   = 4'd7,
    st_beqex  = 4'd8,
    st_addiex = 4'd9,
    st_addiwb = 4'd10,
    st_jex    = 4'd11,
    st_ill    = 4'd12
  } state_t;

  localparam logic [5:0] op_lw    = 6'b100011;
  localparam logic [5:0] op_sw    = 6'b101011;
  localparam logic [5:0] op_rtype = 6'b000000;
  localparam logic [5:0] op_beq   = 6'b000100;
  localparam logic [5:0] op_addi  = 6'b001000;
  localparam logic [5:0] op_j     = 6'b000010;

  localparam logic [1:0] aluop_add   = 2'b00;
  localparam logic [1:0] aluop_sub   = 2'b01;
  localparam logic [1:0] aluop_funct = 2'b10;

  localparam logic [1:0] srcb_reg     = 2'b00;
  localparam logic [1:0] srcb_four    = 2'b01;
  localparam logic [1:0] srcb_imm     = 2'b10;
  localparam logic [1:0] srcb_imm_sh2 = 2'b11;

  localparam logic [1:0] pcsrc_alu    = 2'b00;
  localparam logic [1:0] pcsrc_aluout = 2'b01;
  localparam logic [1:0] pcsrc_jump   = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal_op;
  } ctrl_t;

  // States that wait on the memory handshake.
  function automatic logic is_mem_state(input state_t s);
    return (s == st_fetch) || (s == st_memrd) || (s == st_memwr);
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode
//   Purely combinational state -> control word decode.
//   Ports:
//     state      in   current FSM state
//     mem_ready  in   memory handshake (only affects FETCH writes)
//     ctrl       out  full datapath control word
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_t   state,
  input  logic     mem_ready,
  output ctrl_t    ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      st_fetch: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = srcb_four;
        ctrl.alu_op    = aluop_add;
        ctrl.pc_src    = pcsrc_alu;
        // IR and PC load only on the cycle the fetch completes.
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      st_decode: begin
        ctrl.alu_src_b = srcb_imm_sh2;
        ctrl.alu_op    = aluop_add;
      end
      st_memadr: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = srcb_imm;
        ctrl.alu_op    = aluop_add;
      end
      st_memrd: begin
        ctrl.mem_req  = 1'b1;
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      st_memwb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      st_memwr: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      st_rtex: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = srcb_reg;
        ctrl.alu_op    = aluop_funct;
      end
      st_rtwb: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      st_beqex: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = srcb_reg;
        ctrl.alu_op        = aluop_sub;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_src        = pcsrc_aluout;
      end
      st_addiex: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = srcb_imm;
        ctrl.alu_op    = aluop_add;
      end
      st_addiwb: begin
        ctrl.reg_write = 1'b1;
      end
      st_jex: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = pcsrc_jump;
      end
      st_ill: begin
        ctrl.illegal_op = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_main_control.sv
// mc_main_control
//   Multi-cycle main control FSM for the MIPS datapath. Holds the
//   state register, the opcode latch and next-state logic; the
//   control word comes from mc_ctrl_decode.
//   Ports:
//     clk, reset_n        clock, async active-low reset
//     opcode              IR[31:26], sampled in DECODE
//     mem_ready           memory access completes this cycle
//     mem_req/read/write  memory request and direction
//     i_or_d              address select (0 PC, 1 ALUOut)
//     ir_write, pc_write, pc_write_cond, pc_src
//     alu_src_a, alu_src_b, alu_op
//     reg_dst, mem_to_reg, reg_write
//     illegal_op          one-cycle pulse on undefined opcode
//     state               current state (debug)
//
//   state  | meaning
//   -------+------------------------------------------
//   fetch  | read instruction at PC, PC+4 -> PC
//   decode | branch target -> ALUOut, dispatch opcode
//   memadr | effective address for lw/sw
//   memrd  | data read, wait for mem_ready
//   memwb  | MDR -> rt
//   memwr  | data write, wait for mem_ready
//   rtex   | R-type ALU operation
//   rtwb   | ALUOut -> rd
//   beqex  | compare, conditional PC update
//   addiex | A + imm
//   addiwb | ALUOut -> rt
//   jex    | jump target -> PC
//   ill    | flag undefined opcode, skip instruction
module mc_main_control
  import mc_ctrl_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [OPW-1:0] opcode,
  input  logic           mem_ready,
  output logic           mem_req,
  output logic           mem_read,
  output logic           mem_write,
  output logic           i_or_d,
  output logic           ir_write,
  output logic           pc_write,
  output logic           pc_write_cond,
  output logic [1:0]     pc_src,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     alu_op,
  output logic           reg_dst,
  output logic           mem_to_reg,
  output logic           reg_write,
  output logic           illegal_op,
  output logic [3:0]     state
);

  state_t         state_q;
  state_t         state_d;
  logic [OPW-1:0] op_q;
  ctrl_t          ctrl;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= st_fetch;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == st_decode) op_q <= opcode;
    end
  end

  always_comb begin
    state_d = state_q;
    if (is_mem_state(state_q) && !mem_ready) begin
      state_d = state_q;
    end else begin
      case (state_q)
        st_fetch:  state_d = st_decode;
        st_decode: begin
          case (opcode)
            op_lw, op_sw: state_d = st_memadr;
            op_rtype:     state_d = st_rtex;
            op_beq:       state_d = st_beqex;
            op_addi:      state_d = st_addiex;
            op_j:         state_d = st_jex;
            default:      state_d = st_ill;
          endcase
        end
        st_memadr: state_d = (op_q == op_lw) ? st_memrd : st_memwr;
        st_memrd:  state_d = st_memwb;
        st_rtex:   state_d = st_rtwb;
        st_addiex: state_d = st_addiwb;
        default:   state_d = st_fetch;
      endcase
    end
  end

  mc_ctrl_decode u_decode (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // Reset parks the FSM in FETCH, whose decode would otherwise let
  // mem_ready through to the IR/PC loads; hold them off while in reset.
  assign ir_write      = ctrl.ir_write & reset_n;
  assign pc_write      = ctrl.pc_write & reset_n;
  assign mem_req       = ctrl.mem_req;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign i_or_d        = ctrl.i_or_d;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign pc_src        = ctrl.pc_src;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_write     = ctrl.reg_write;
  assign illegal_op    = ctrl.illegal_op;
  assign state         = state_q;

endmodule
